// File: rtl/scan_chain_receiver_pkg.sv
// scan_chain_receiver_pkg: shared frame geometry and FSM state type for the scan chain
package scan_chain_receiver_pkg;
   localparam int DEF_ADDR_BITS    = 12;
   localparam int DEF_PAYLOAD_BITS = 160;
   localparam int FRAME_BITS       = DEF_ADDR_BITS + DEF_PAYLOAD_BITS;
   localparam int CNT_W            = $clog2(FRAME_BITS + 2);
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
endpackage

// File: rtl/scan_sync_edge.sv
// scan_sync_edge: synchronizes one async bit and reports its level plus rise/fall pulses
module scan_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_level;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_synced;
   assign w_synced = r_sync[SYNC_STAGES-1];
   // synchronizer chain, then an edge stage whose level and edge flags update together
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync  <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_level <= w_synced;
         r_rise  <= w_synced & ~r_level;
         r_fall  <= ~w_synced & r_level;
      end
   end
   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;
endmodule

// File: rtl/scan_chain_receiver.sv
// scan_chain_receiver: rebuilds {addr, payload} frames from an async scan chain onto a valid/ready port
module scan_chain_receiver
   import scan_chain_receiver_pkg::*;
#(
   parameter int ADDR_BITS    = DEF_ADDR_BITS,
   parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
   parameter int SYNC_STAGES  = 2,
   localparam int FRM_BITS    = ADDR_BITS + PAYLOAD_BITS,
   localparam int CNT_BITS    = $clog2(FRM_BITS + 2)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    scan_clk,
   input  logic                    scan_en,
   input  logic                    scan_in,
   input  logic                    scan_reset,
   output logic                    frame_valid,
   input  logic                    frame_ready,
   output logic [ADDR_BITS-1:0]    frame_addr,
   output logic [PAYLOAD_BITS-1:0] frame_payload,
   output logic                    frame_error,
   output logic                    overflow,
   output logic [CNT_BITS-1:0]     bit_count
);
   localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(FRM_BITS);
   localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(FRM_BITS + 1);

   logic w_sclk_rise;
   logic w_en_level;
   logic w_en_fall;
   logic w_in_level;
   logic w_srst;

   scan_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
      .clk(clk), .reset(reset), .i_async(scan_clk),
      .o_level(), .o_rise(w_sclk_rise), .o_fall()
   );
   scan_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
      .clk(clk), .reset(reset), .i_async(scan_en),
      .o_level(w_en_level), .o_rise(), .o_fall(w_en_fall)
   );
   scan_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_in (
      .clk(clk), .reset(reset), .i_async(scan_in),
      .o_level(w_in_level), .o_rise(), .o_fall()
   );
   scan_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rst (
      .clk(clk), .reset(reset), .i_async(scan_reset),
      .o_level(w_srst), .o_rise(), .o_fall()
   );

   state_t                  r_state;
   logic [CNT_BITS-1:0]     r_cnt;
   logic [FRM_BITS-1:0]     r_shreg;
   logic                    r_valid;
   logic [ADDR_BITS-1:0]    r_addr;
   logic [PAYLOAD_BITS-1:0] r_payload;
   logic                    r_error;
   logic                    r_overflow;

   logic w_shift;
   logic w_eval;
   logic w_full;
   logic w_hs;
   logic w_load;
   logic w_drop_ovf;
   logic w_drop_err;

   // frame-end decode; a scan-chain clear masks evaluation so it never reports errors
   always_comb begin
      w_shift    = w_sclk_rise & w_en_level;
      w_eval     = ~w_srst & (r_state == SHIFT) & w_en_fall;
      w_full     = (r_cnt == CNT_FULL);
      w_hs       = r_valid & frame_ready;
      w_load     = w_eval & w_full & (~r_valid | w_hs);
      w_drop_ovf = w_eval & w_full & r_valid & ~w_hs;
      w_drop_err = w_eval & ~w_full;
   end

   // FSM, bit counter and shift register; the register keeps its contents when a frame closes
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_shreg <= '0;
      end else if (w_srst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_shreg <= '0;
      end else if (w_eval) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else if (w_shift) begin
         r_state <= SHIFT;
         r_shreg <= {r_shreg[FRM_BITS-2:0], w_in_level};
         r_cnt   <= (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
      end
   end

   // output holding register; a same-cycle handshake frees the slot for the incoming frame
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_valid   <= 1'b0;
         r_addr    <= '0;
         r_payload <= '0;
      end else if (w_load) begin
         r_valid   <= 1'b1;
         r_addr    <= r_shreg[FRM_BITS-1 -: ADDR_BITS];
         r_payload <= r_shreg[PAYLOAD_BITS-1:0];
      end else if (w_hs) begin
         r_valid   <= 1'b0;
      end
   end

   // single-cycle status pulses for dropped frames
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_error    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_error    <= w_drop_err;
         r_overflow <= w_drop_ovf;
      end
   end

   assign frame_valid   = r_valid;
   assign frame_addr    = r_addr;
   assign frame_payload = r_payload;
   assign frame_error   = r_error;
   assign overflow      = r_overflow;
   assign bit_count     = r_cnt;
endmodule

// File: tb/tb_scan_chain_receiver.sv
// tb_scan_chain_receiver: scoreboard bench for scan_chain_receiver with directed frames
module tb_scan_chain_receiver;
   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         scan_clk = 1'b0;
   logic         scan_en = 1'b0;
   logic         scan_in = 1'b0;
   logic         scan_reset = 1'b0;
   logic         frame_ready = 1'b1;
   logic         frame_valid;
   logic [11:0]  frame_addr;
   logic [159:0] frame_payload;
   logic         frame_error;
   logic         overflow;
   logic [7:0]   bit_count;

   scan_chain_receiver dut (
      .clk(clk), .reset(reset), .scan_clk(scan_clk), .scan_en(scan_en),
      .scan_in(scan_in), .scan_reset(scan_reset), .frame_valid(frame_valid),
      .frame_ready(frame_ready), .frame_addr(frame_addr), .frame_payload(frame_payload),
      .frame_error(frame_error), .overflow(overflow), .bit_count(bit_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int n_err = 0;
   int n_ovf = 0;
   int peak = 0;
   logic [171:0] sb_q[$];

   localparam logic [171:0] FA = {12'hA5C, 160'h1234_5678_9ABC_DEF0_0011_2233_4455_6677_89AB_CDEF};
   localparam logic [171:0] FB = {12'h3C1, 160'hFEDC_BA98_7654_3210_0F0F_F0F0_AAAA_5555_C3C3_0001};
   localparam logic [171:0] FC = {12'h801, 160'h8000_0000_0000_0000_0000_0000_0000_0000_0000_0001};
   localparam logic [171:0] FD = {12'h07E, 160'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0_0102_0304};

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input int n, input logic [171:0] d, input bit keep_en);
      scan_en = 1'b1;
      wait_cyc(4);
      for (int i = 0; i < n; i++) begin
         scan_in = (i < 172) ? d[171-i] : 1'b1;
         wait_cyc(3);
         scan_clk = 1'b1;
         wait_cyc(3);
         scan_clk = 1'b0;
      end
      if (!keep_en) begin
         wait_cyc(2);
         scan_en = 1'b0;
         wait_cyc(8);
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      while (sb_q.size() != 0 && t < 200) begin
         wait_cyc(1);
         t++;
      end
      chk("sb_drain", 192'(sb_q.size()), 192'd0);
   endtask

   // monitor: pops the scoreboard on every handshake and tallies status pulses
   always @(negedge clk) begin
      logic [171:0] exp;
      if (int'(bit_count) > peak) peak = int'(bit_count);
      if (frame_error) n_err++;
      if (overflow) n_ovf++;
      if (frame_valid && frame_ready) begin
         n_chk++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame_unexpected: got %0h expected none", {frame_addr, frame_payload});
         end else begin
            exp = sb_q.pop_front();
            if ({frame_addr, frame_payload} !== exp) begin
               n_fail++;
               $display("FAIL frame_data: got %0h expected %0h", {frame_addr, frame_payload}, exp);
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int e0;
      int o0;
      wait_cyc(5);
      chk("rst_valid", 192'(frame_valid), 192'd0);
      chk("rst_addr", 192'(frame_addr), 192'd0);
      chk("rst_payload", 192'(frame_payload), 192'd0);
      chk("rst_count", 192'(bit_count), 192'd0);
      reset = 1'b1;
      wait_cyc(3);
      // 1: single good frame
      peak = 0;
      sb_q.push_back(FA);
      send_bits(172, FA, 1'b0);
      wait_drain();
      chk("t1_peak", 192'(peak), 192'd172);
      chk("t1_err", 192'(n_err), 192'd0);
      // 2: short and long frames error, then a good one
      send_bits(171, FA, 1'b0);
      send_bits(173, FB, 1'b0);
      chk("t2_err", 192'(n_err), 192'd2);
      chk("t2_valid", 192'(frame_valid), 192'd0);
      sb_q.push_back(FB);
      send_bits(172, FB, 1'b0);
      wait_drain();
      // 3: overflow while output is held
      frame_ready = 1'b0;
      sb_q.push_back(FC);
      send_bits(172, FC, 1'b0);
      send_bits(172, FD, 1'b0);
      chk("t3_ovf", 192'(n_ovf), 192'd1);
      chk("t3_valid", 192'(frame_valid), 192'd1);
      chk("t3_addr", 192'(frame_addr), 192'(FC[171:160]));
      chk("t3_payload", 192'(frame_payload), 192'(FC[159:0]));
      frame_ready = 1'b1;
      wait_drain();
      wait_cyc(2);
      chk("t3_clear", 192'(frame_valid), 192'd0);
      // 4: back-to-back frames with ready held high
      o0 = n_ovf;
      sb_q.push_back(FD);
      send_bits(172, FD, 1'b0);
      sb_q.push_back(FA);
      send_bits(172, FA, 1'b0);
      sb_q.push_back(FC);
      send_bits(172, FC, 1'b0);
      wait_drain();
      chk("t4_ovf", 192'(n_ovf), 192'(o0));
      // 5a: scan_reset mid-frame
      e0 = n_err;
      send_bits(80, FB, 1'b1);
      wait_cyc(2);
      scan_reset = 1'b1;
      wait_cyc(6);
      chk("t5_count_clr", 192'(bit_count), 192'd0);
      scan_reset = 1'b0;
      wait_cyc(2);
      scan_en = 1'b0;
      wait_cyc(8);
      chk("t5_no_err", 192'(n_err), 192'(e0));
      sb_q.push_back(FB);
      send_bits(172, FB, 1'b0);
      wait_drain();
      // 5b: system reset mid-frame with a pending frame
      frame_ready = 1'b0;
      send_bits(172, FD, 1'b0);
      chk("t5_pending", 192'(frame_addr), 192'(FD[171:160]));
      send_bits(50, FA, 1'b1);
      reset = 1'b0;
      wait_cyc(1);
      chk("t5_rst_valid", 192'(frame_valid), 192'd0);
      chk("t5_rst_data", 192'({frame_addr, frame_payload}), 192'd0);
      chk("t5_rst_count", 192'(bit_count), 192'd0);
      chk("t5_rst_pulse", 192'({frame_error, overflow}), 192'd0);
      scan_en = 1'b0;
      wait_cyc(5);
      reset = 1'b1;
      frame_ready = 1'b1;
      wait_cyc(5);
      e0 = n_err;
      sb_q.push_back(FA);
      send_bits(172, FA, 1'b0);
      wait_drain();
      chk("t5_after_err", 192'(n_err), 192'(e0));
      // 6: scan_clk toggling with scan_en low
      peak = 0;
      o0 = n_ovf;
      for (int i = 0; i < 200; i++) begin
         scan_clk = 1'b1;
         wait_cyc(3);
         scan_clk = 1'b0;
         wait_cyc(3);
      end
      wait_cyc(8);
      chk("t6_peak", 192'(peak), 192'd0);
      chk("t6_err", 192'(n_err), 192'(e0));
      chk("t6_ovf", 192'(n_ovf), 192'(o0));
      chk("t6_valid", 192'(frame_valid), 192'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
